debounced_updown_counter: RTL and testbench
===========================================

Name: debounced_updown_counter

Overview:
Parametrised successor to the single-button edge counter used in the super_counter example. It takes two raw push-button inputs (increment, decrement) and passes each through a 2-flop synchroniser and a stability debouncer. The result drives a WIDTH-bit up/down counter with selectable wrap or saturate mode, a synchronous clear, a stretched activity LED and a limit-event pulse. It sits between board button pins and display/LED logic in the hw_examples designs.

Parameters:
WIDTH, 8, counter width in bits (>=2)
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised input must differ from its debounced state before that state flips (>=1)
STEP, 1, amount added or subtracted per accepted press (1..2^WIDTH-1)
SATURATE, 0, 0 = wrap modulo 2^WIDTH; 1 = clamp at 0 and 2^WIDTH-1
LED_PULSE_CYCLES, 3, cycles led stays high after each count change (>=1)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
btn_inc  input  1  raw increment button, asynchronous, active-high
btn_dec  input  1  raw decrement button, asynchronous, active-high
clear  input  1  synchronous count clear, active-high
count  output  WIDTH  current counter value (registered)
led  output  1  activity indicator, stretched
limit  output  1  one-cycle pulse on wrap or saturation clamp

Behaviour:
- Reset (clk edge with rst=1): all of the following go to 0, and reset overrides every other input:
  - synchroniser flops, debounce counters, debounced states, edge-detect flops;
  - count, led, LED timer, limit.
- Synchroniser, per button: two flops, reset to 0.
- Debouncer, per button: counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits.
  - If the synchronised value equals the debounced state, the counter clears.
  - Otherwise the counter increments.
  - When the counter already holds DEBOUNCE_CYCLES-1 and the values still differ, the debounced state flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles produce no flip.
- Press event: debounced state 1 while its previous-cycle value is 0. Exactly one cycle per press. Release produces no event.
- Latency: a button raised and held stable changes count on rising edge number DEBOUNCE_CYCLES+3, counting the first edge that samples it high as edge 1. With the default, that is edge 7.
- Count update priority, evaluated each cycle:
  1. clear: count<=0, no limit, led not retriggered.
  2. Both inc and dec events in the same cycle: they cancel. No change, no led, no limit.
  3. inc event only: count+STEP.
  4. dec event only: count-STEP.
- Wrap mode (SATURATE=0):
  - Arithmetic is modulo 2^WIDTH.
  - limit=1 in the cycle count updates when the true sum exceeds 2^WIDTH-1 or the true difference is below 0.
- Saturate mode (SATURATE=1):
  - Results are clamped to 2^WIDTH-1 or 0.
  - limit=1 whenever clamping occurred, including a press at an already-reached limit.
  - A press with count already at the limit leaves count unchanged and does not retrigger led.
- limit is registered, high for exactly one cycle, aligned with the count update edge.
- LED:
  - Any edge at which count takes a different value loads the LED timer with LED_PULSE_CYCLES.
  - led is 1 while the timer is non-zero; the timer decrements each cycle.
  - A new change while lit reloads the timer; pulses extend, they do not accumulate.
  - led rises on the same edge as the count change.
- Clear from nonzero count: this is a value change, so it does retrigger led.
- Button held across reset release: after release it counts as one new press after the full latency.
- rst asserted mid-debounce: the pending flip is discarded.

Test Plan:
- Defaults. Hold btn_inc high 10 cycles from reset -> count 0->1 on edge 7 after assertion; led high 3 cycles; limit stays 0; only one increment.
- Defaults. btn_inc pulses of 3 cycles high / 3 low, repeated 5 times -> count stays 0, led never high.
- Wrap, STEP=1, count=255, one debounced inc press -> count=0, limit high exactly 1 cycle. Then dec -> count=255, limit pulse.
- SATURATE=1. count=255, inc press -> count stays 255, limit pulses, led stays low. count=0, dec -> stays 0, limit pulses.
- btn_inc and btn_dec rise on the same cycle, held -> count unchanged, no led, no limit.
- count=5, inc event coincides with clear -> count=0, led retriggered.
- count=5, rst asserted 2 cycles in mid-debounce of btn_dec -> count=0, no decrement appears afterward until btn_dec is released and re-pressed.

Source files
------------

// File: rtl/debounced_updown_counter.sv
// Two-button up/down counter: each raw button is synchronised, debounced and
// edge-detected, then drives a wrap/saturate counter with an activity LED and a limit pulse.
module debounced_updown_counter #(
  parameter int WIDTH            = 8,
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int STEP             = 1,
  parameter int SATURATE         = 0,
  parameter int LED_PULSE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_inc,
  input  logic             btn_dec,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             led,
  output logic             limit
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LED_W = $clog2(LED_PULSE_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LED_W-1:0] LED_LOAD = LED_W'(LED_PULSE_CYCLES);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

  // Bit 0 is the increment button, bit 1 the decrement button.
  logic [1:0]      raw;
  logic [1:0]      sync1, sync2;
  logic [1:0]      db_state, db_prev;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      press;

  logic [LED_W-1:0] led_timer;

  assign raw   = {btn_dec, btn_inc};
  assign press = db_state & ~db_prev;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      db_state <= '0;
      db_prev  <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      db_prev <= db_state;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_state[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_state[i] <= ~db_state[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic [WIDTH:0]   sum_x;
  logic [WIDTH-1:0] diff;
  logic             under;
  logic [WIDTH-1:0] next_count;
  logic             next_limit;

  assign sum_x = {1'b0, count} + {1'b0, STEP_W};
  assign diff  = count - STEP_W;
  assign under = (count < STEP_W);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    next_count = count;
    next_limit = 1'b0;
    if (clear) begin
      next_count = '0;
    end else if (press == 2'b01) begin
      if (sum_x[WIDTH]) begin
        next_limit = 1'b1;
        next_count = (SATURATE != 0) ? '1 : sum_x[WIDTH-1:0];
      end else begin
        next_count = sum_x[WIDTH-1:0];
      end
    end else if (press == 2'b10) begin
      if (under) begin
        next_limit = 1'b1;
        next_count = (SATURATE != 0) ? '0 : diff;
      end else begin
        next_count = diff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      limit     <= 1'b0;
      led_timer <= '0;
    end else begin
      count <= next_count;
      limit <= next_limit;
      // Any actual value change (including a clear from nonzero) relights the LED.
      if (next_count != count)  led_timer <= LED_LOAD;
      else if (led_timer != '0) led_timer <= led_timer - 1'b1;
    end
  end

  assign led = (led_timer != '0);

endmodule

// File: tb/tb_debounced_updown_counter.sv
// Randomised bench for debounced_updown_counter: a wrap-mode and a saturate-mode
// instance share stimulus and are compared every cycle against a behavioural model.
module tb_debounced_updown_counter;

  logic       clk = 1'b0;
  logic       rst, btn_inc, btn_dec, clear;
  logic [7:0] w_count, s_count;
  logic       w_led, w_limit, s_led, s_limit;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  always #5 clk = ~clk;

  debounced_updown_counter dut_wrap (
    .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec), .clear(clear),
    .count(w_count), .led(w_led), .limit(w_limit)
  );

  debounced_updown_counter #(.STEP(3), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec), .clear(clear),
    .count(s_count), .led(s_led), .limit(s_limit)
  );

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Behavioural model: a button is seen two edges late; after it has disagreed
  // with its debounced level for 4 consecutive edges the level flips, and a
  // rising flip becomes a press applied at the following edge.
  int s1 [2], s2 [2], db [2], run [2];
  bit pend [2];
  int m_cnt [2], m_tim [2];
  bit m_lim [2];

  always @(posedge clk) begin
    int step, nv;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        s1[b] = 0; s2[b] = 0; db[b] = 0; run[b] = 0; pend[b] = 0;
        m_cnt[b] = 0; m_tim[b] = 0; m_lim[b] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        step     = (k == 0) ? 1 : 3;
        nv       = m_cnt[k];
        m_lim[k] = 0;
        if (clear)                 nv = 0;
        else if (pend[0] && !pend[1]) nv = nv + step;
        else if (pend[1] && !pend[0]) nv = nv - step;
        if (nv > 255) begin
          m_lim[k] = 1;
          nv = (k == 0) ? nv - 256 : 255;
        end else if (nv < 0) begin
          m_lim[k] = 1;
          nv = (k == 0) ? nv + 256 : 0;
        end
        if (nv != m_cnt[k])    m_tim[k] = 3;
        else if (m_tim[k] > 0) m_tim[k] = m_tim[k] - 1;
        m_cnt[k] = nv;
      end
      for (int b = 0; b < 2; b++) begin
        pend[b] = 0;
        if (s2[b] != db[b]) begin
          run[b]++;
          if (run[b] == 4) begin
            db[b]   = 1 - db[b];
            run[b]  = 0;
            pend[b] = (db[b] == 1);
          end
        end else begin
          run[b] = 0;
        end
      end
      s2[0] = s1[0]; s2[1] = s1[1];
      s1[0] = int'(btn_inc); s1[1] = int'(btn_dec);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("wrap_count", int'(w_count), m_cnt[0]);
      check("wrap_led",   int'(w_led),   int'(m_tim[0] != 0));
      check("wrap_limit", int'(w_limit), int'(m_lim[0]));
      check("sat_count",  int'(s_count), m_cnt[1]);
      check("sat_led",    int'(s_led),   int'(m_tim[1] != 0));
      check("sat_limit",  int'(s_limit), int'(m_lim[1]));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit inc, input bit dec, input int hold, input int gap);
    btn_inc = inc; btn_dec = dec;
    cycles(hold);
    btn_inc = 1'b0; btn_dec = 1'b0;
    cycles(gap);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
  endtask

  initial begin
    int mode, hold, gap;
    rst = 1'b1; btn_inc = 1'b0; btn_dec = 1'b0; clear = 1'b0;
    cycles(1);
    chk_en = 1'b1;
    cycles(1);
    check("reset_count", int'(w_count), 0);
    check("reset_led",   int'(w_led),   0);
    rst = 1'b0;

    // Long hold gives exactly one increment.
    press(1, 0, 10, 12);
    check("hold_once", int'(w_count), 1);

    // 3-cycle glitches never survive the debouncer.
    repeat (5) press(1, 0, 3, 3);
    cycles(8);
    check("glitch_count", int'(w_count), 1);

    // 1 -> 0 -> 255 (wrap) / 3 -> 0 -> 0 (clamp), then back up.
    press(0, 1, 6, 8);
    press(0, 1, 6, 8);
    check("wrap_under", int'(w_count), 255);
    check("sat_floor",  int'(s_count), 0);
    press(1, 0, 6, 8);
    check("wrap_over", int'(w_count), 0);

    // Simultaneous presses cancel.
    press(1, 1, 10, 10);
    check("both_cancel", int'(w_count), 0);

    // Clear coinciding with an inc event at count 5.
    repeat (5) press(1, 0, 6, 6);
    check("pre_clear", int'(w_count), 5);
    btn_inc = 1'b1;
    cycles(6);
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    check("clear_win", int'(w_count), 0);
    check("clear_led", int'(w_led), 1);
    btn_inc = 1'b0;
    cycles(10);

    // Reset during a pending dec flip discards it.
    repeat (5) press(1, 0, 6, 6);
    btn_dec = 1'b1;
    cycles(3);
    rst = 1'b1;
    cycles(2);
    btn_dec = 1'b0;
    rst = 1'b0;
    cycles(15);
    check("rst_discard", int'(w_count), 0);
    press(0, 1, 6, 8);
    check("repress_dec", int'(w_count), 255);

    // Button held across reset release registers as a fresh press.
    btn_inc = 1'b1;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(12);
    btn_inc = 1'b0;
    cycles(8);
    check("held_rst", int'(w_count), 1);

    // Drive the saturating instance into its top clamp.
    do_clear();
    repeat (90) press(1, 0, 6, 6);
    check("sat_ceiling", int'(s_count), 255);

    // Randomised presses, glitches and occasional clears.
    for (int it = 0; it < 300; it++) begin
      mode = $urandom_range(0, 9);
      hold = $urandom_range(1, 10);
      gap  = $urandom_range(1, 8);
      if ($urandom_range(0, 15) == 0) do_clear();
      case (mode)
        0, 1, 2, 3: press(1, 0, hold, gap);
        4, 5, 6:    press(0, 1, hold, gap);
        7:          press(1, 1, hold, gap);
        default: begin
          btn_inc = 1'b1;
          cycles(hold);
          btn_dec = 1'b1;
          cycles($urandom_range(1, 6));
          btn_inc = 1'b0;
          cycles($urandom_range(1, 6));
          btn_dec = 1'b0;
          cycles(gap);
        end
      endcase
    end
    cycles(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
